// File: rtl/blit_readmem.sv
// Blitter read-memory stage: accepts pixel requests, issues source reads for
// memory pixels, and emits every pixel in acceptance order as {dest, data}.
// An order FIFO keeps acceptance order; a read-data FIFO buffers returned bytes.
// Read credits bound reserved reads, so returned data always has room.
module blit_readmem #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        readmem_ready,
    input  logic        readmem_valid,
    input  logic        readmem_is_mem,
    input  logic [25:0] readmem_dest_addr,
    input  logic [25:0] readmem_src_addr,
    output logic        mem_request,
    input  logic        mem_ready,
    output logic [25:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    input  logic        writemem_ready,
    output logic        writemem_valid,
    output logic [25:0] writemem_dest_addr,
    output logic [7:0]  writemem_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Order FIFO entry layout: {is_mem, dest[25:0], colour[7:0]}
    logic [34:0]   order_mem [DEPTH];
    logic [7:0]    rdata_mem [DEPTH];

    logic [AW:0]   order_wr_ptr_reg, order_wr_ptr_next;
    logic [AW:0]   order_rd_ptr_reg, order_rd_ptr_next;
    logic [AW:0]   rdata_wr_ptr_reg, rdata_wr_ptr_next;
    logic [AW:0]   rdata_rd_ptr_reg, rdata_rd_ptr_next;
    logic [CW-1:0] credits_reg, credits_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic          pending_reg, pending_next;
    logic [25:0]   pend_addr_reg, pend_addr_next;

    logic          order_full;
    logic          order_empty;
    logic          rdata_empty;
    logic [34:0]   head;
    logic          head_is_mem;
    logic          accept;
    logic          accept_mem;
    logic          pop;
    logic          rdata_push;
    logic          rdata_pop;
    logic          mem_hs;

    // Extra pointer bit distinguishes full from empty after wrap.
    assign order_empty = (order_wr_ptr_reg == order_rd_ptr_reg);
    assign order_full  = (order_wr_ptr_reg[AW] != order_rd_ptr_reg[AW]) &&
                         (order_wr_ptr_reg[AW-1:0] == order_rd_ptr_reg[AW-1:0]);
    assign rdata_empty = (rdata_wr_ptr_reg == rdata_rd_ptr_reg);

    assign head        = order_mem[order_rd_ptr_reg[AW-1:0]];
    assign head_is_mem = head[34];

    // Ready never looks at valid/is_mem; a stalled pending read blocks new work.
    assign readmem_ready = !order_full && (credits_reg < DEPTH_C) &&
                           !(pending_reg && !mem_ready);
    assign accept     = readmem_valid && readmem_ready;
    assign accept_mem = accept && readmem_is_mem;

    // Head blocks: a memory pixel waits for its byte, and nothing passes it.
    assign writemem_valid     = !order_empty && (!head_is_mem || !rdata_empty);
    assign writemem_dest_addr = head[33:8];
    assign writemem_data      = head_is_mem ? rdata_mem[rdata_rd_ptr_reg[AW-1:0]] : head[7:0];
    assign pop                = writemem_valid && writemem_ready;

    // Returns with nothing outstanding are leftovers from before a reset.
    assign rdata_push = mem_rvalid && (outstanding_reg != '0);
    assign rdata_pop  = pop && head_is_mem;

    assign mem_hs      = pending_reg && mem_ready;
    assign mem_request = pending_reg;
    assign mem_addr    = pend_addr_reg;

    // Next-state computation for pointers, credits, outstanding count and pending read.
    always_comb begin
        order_wr_ptr_next = order_wr_ptr_reg + (accept ? 1'b1 : 1'b0);
        order_rd_ptr_next = order_rd_ptr_reg + (pop ? 1'b1 : 1'b0);
        rdata_wr_ptr_next = rdata_wr_ptr_reg + (rdata_push ? 1'b1 : 1'b0);
        rdata_rd_ptr_next = rdata_rd_ptr_reg + (rdata_pop ? 1'b1 : 1'b0);

        credits_next = credits_reg;
        case ({accept_mem, rdata_pop})
            2'b10:   credits_next = credits_reg + 1'b1;
            2'b01:   credits_next = credits_reg - 1'b1;
            default: credits_next = credits_reg;
        endcase

        outstanding_next = outstanding_reg;
        case ({mem_hs, rdata_push})
            2'b10:   outstanding_next = outstanding_reg + 1'b1;
            2'b01:   outstanding_next = outstanding_reg - 1'b1;
            default: outstanding_next = outstanding_reg;
        endcase

        // A new read accepted in the handshake cycle replaces the one just issued.
        pending_next   = pending_reg;
        pend_addr_next = pend_addr_reg;
        if (accept_mem) begin
            pending_next   = 1'b1;
            pend_addr_next = readmem_src_addr;
        end else if (mem_hs) begin
            pending_next   = 1'b0;
        end
    end

    // Control state register; reset discards everything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            order_wr_ptr_reg <= '0;
            order_rd_ptr_reg <= '0;
            rdata_wr_ptr_reg <= '0;
            rdata_rd_ptr_reg <= '0;
            credits_reg      <= '0;
            outstanding_reg  <= '0;
            pending_reg      <= 1'b0;
            pend_addr_reg    <= '0;
        end else begin
            order_wr_ptr_reg <= order_wr_ptr_next;
            order_rd_ptr_reg <= order_rd_ptr_next;
            rdata_wr_ptr_reg <= rdata_wr_ptr_next;
            rdata_rd_ptr_reg <= rdata_rd_ptr_next;
            credits_reg      <= credits_next;
            outstanding_reg  <= outstanding_next;
            pending_reg      <= pending_next;
            pend_addr_reg    <= pend_addr_next;
        end
    end

    // FIFO storage writes; contents need no reset since pointers gate visibility.
    always_ff @(posedge clock) begin
        if (accept) begin
            order_mem[order_wr_ptr_reg[AW-1:0]] <=
                {readmem_is_mem, readmem_dest_addr, readmem_src_addr[7:0]};
        end
        if (rdata_push) begin
            rdata_mem[rdata_wr_ptr_reg[AW-1:0]] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_blit_readmem.sv
// Testbench for blit_readmem: table-driven directed scenarios plus a randomized
// phase, all checked against an acceptance-order pixel scoreboard and a small
// in-order memory model.
module tb_blit_readmem;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        readmem_ready;
    logic        readmem_valid;
    logic        readmem_is_mem;
    logic [25:0] readmem_dest_addr;
    logic [25:0] readmem_src_addr;
    logic        mem_request;
    logic        mem_ready;
    logic [25:0] mem_addr;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        writemem_ready;
    logic        writemem_valid;
    logic [25:0] writemem_dest_addr;
    logic [7:0]  writemem_data;

    blit_readmem #(.DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .readmem_ready      (readmem_ready),
        .readmem_valid      (readmem_valid),
        .readmem_is_mem     (readmem_is_mem),
        .readmem_dest_addr  (readmem_dest_addr),
        .readmem_src_addr   (readmem_src_addr),
        .mem_request        (mem_request),
        .mem_ready          (mem_ready),
        .mem_addr           (mem_addr),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata),
        .writemem_ready     (writemem_ready),
        .writemem_valid     (writemem_valid),
        .writemem_dest_addr (writemem_dest_addr),
        .writemem_data      (writemem_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [25:0] dest;
        logic [7:0]  data;
    } pix_t;

    typedef struct packed {
        int          due;
        logic [7:0]  data;
    } ret_t;

    typedef struct packed {
        logic        is_mem;
        logic [25:0] dest;
        logic [25:0] src;
        logic [7:0]  exp_data;
    } vec_t;

    pix_t        exp_q[$];
    logic [25:0] rd_q[$];
    ret_t        ret_q[$];
    logic [7:0]  mem_img [logic [25:0]];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          issue_cnt = 0;
    int          mem_lat = 3;
    int          stall = 0;
    int          stale = 0;
    bit          rand_mready = 0;
    bit          last_acc = 0;
    logic [7:0]  req_exp = 8'h00;
    bit          held_w = 0;
    logic [25:0] held_dest;
    logic [7:0]  held_data;
    bit          held_m = 0;
    logic [25:0] held_addr;

    vec_t        vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Contents of the modelled memory.
    function automatic logic [7:0] memfn(input logic [25:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // One clock cycle: drive memory side, sample at mid-cycle, update model, advance.
    task automatic tick();
        bit   acc;
        bit   hs;
        bit   pop;
        ret_t r;
        mem_ready = (stall > 0) ? 1'b0 : (rand_mready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (stale > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'hEE;
        end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ret_q[0].data;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 8'($urandom);
        end
        #1;
        if (held_w) begin
            chk("hold_valid", 64'(writemem_valid), 64'd1);
            chk("hold_pixel", {writemem_dest_addr, writemem_data}, {held_dest, held_data});
        end
        if (held_m) begin
            chk("hold_request", 64'(mem_request), 64'd1);
            chk("hold_addr", 64'(mem_addr), 64'(held_addr));
        end
        acc = readmem_valid && readmem_ready;
        hs  = mem_request && mem_ready;
        pop = writemem_valid && writemem_ready;
        if (hs) begin
            issue_cnt++;
            r.data = memfn(mem_addr);
            r.due  = cyc + mem_lat;
            if (ret_q.size() > 0 && r.due < ret_q[$].due) r.due = ret_q[$].due;
            ret_q.push_back(r);
            if (rd_q.size() == 0) fail_now("spurious_read");
            else chk("read_addr", 64'(mem_addr), 64'(rd_q.pop_front()));
        end
        if (pop) begin
            $display("pixel out dest=%07h data=%02h", writemem_dest_addr, writemem_data);
            if (exp_q.size() == 0) fail_now("extra_pixel");
            else chk("pixel", {writemem_dest_addr, writemem_data}, exp_q.pop_front());
        end
        if (acc) begin
            $display("request in is_mem=%0d dest=%07h src=%07h", readmem_is_mem,
                     readmem_dest_addr, readmem_src_addr);
            exp_q.push_back({readmem_dest_addr, req_exp});
            if (readmem_is_mem) rd_q.push_back(readmem_src_addr);
        end
        if (mem_rvalid) begin
            if (stale > 0) stale--;
            else void'(ret_q.pop_front());
        end
        held_w    = writemem_valid && !writemem_ready;
        held_dest = writemem_dest_addr;
        held_data = writemem_data;
        held_m    = mem_request && !mem_ready;
        held_addr = mem_addr;
        last_acc  = acc;
        if (stall > 0) stall--;
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic send_req(input logic is_mem, input logic [25:0] dest,
                            input logic [25:0] src, input logic [7:0] exp_data);
        int n;
        readmem_valid     = 1'b1;
        readmem_is_mem    = is_mem;
        readmem_dest_addr = dest;
        readmem_src_addr  = src;
        req_exp           = exp_data;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) fail_now("accept_timeout");
        readmem_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || ret_q.size() > 0 || rd_q.size() > 0) && n < limit) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0 || ret_q.size() > 0 || rd_q.size() > 0) fail_now("drain_timeout");
        chk("idle_valid", 64'(writemem_valid), 64'd0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        readmem_valid  = 1'b0;
        mem_rvalid     = 1'b0;
        exp_q.delete();
        rd_q.delete();
        ret_q.delete();
        held_w = 0;
        held_m = 0;
        #1;
        chk("rst_readmem_ready", 64'(readmem_ready), 64'd1);
        chk("rst_mem_request", 64'(mem_request), 64'd0);
        chk("rst_writemem_valid", 64'(writemem_valid), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int accs;
        reset = 1'b1;
        readmem_valid = 0; readmem_is_mem = 0; readmem_dest_addr = '0; readmem_src_addr = '0;
        mem_ready = 1; mem_rvalid = 0; mem_rdata = '0; writemem_ready = 1;

        vecs[0] = '{1'b0, 26'h100, 26'h0000AB, 8'hAB};
        vecs[1] = '{1'b0, 26'h101, 26'h0000AB, 8'hAB};
        vecs[2] = '{1'b0, 26'h102, 26'h0000AB, 8'hAB};
        vecs[3] = '{1'b0, 26'h103, 26'h0000AB, 8'hAB};
        vecs[4] = '{1'b1, 26'h1000, 26'h200, 8'h11};
        vecs[5] = '{1'b1, 26'h1001, 26'h201, 8'h22};
        vecs[6] = '{1'b1, 26'h1002, 26'h202, 8'h33};
        vecs[7] = '{1'b1, 26'h2000, 26'h300, 8'h3C};
        vecs[8] = '{1'b0, 26'h2001, 26'h0000CC, 8'hCC};
        mem_img[26'h200] = 8'h11;
        mem_img[26'h201] = 8'h22;
        mem_img[26'h202] = 8'h33;
        mem_img[26'h300] = 8'h3C;
        mem_img[26'h500] = 8'h5C;

        @(negedge clock);
        do_reset();

        // Fill: pass-through pixels, no memory traffic, 1-cycle latency.
        base = issue_cnt;
        for (int i = 0; i < 4; i++) begin
            send_req(vecs[i].is_mem, vecs[i].dest, vecs[i].src, vecs[i].exp_data);
            if (i == 0) begin
                chk("fill_latency_valid", 64'(writemem_valid), 64'd1);
                chk("fill_first_dest", 64'(writemem_dest_addr), 64'h100);
            end
        end
        wait_drain(50);
        chk("fill_no_reads", 64'(issue_cnt - base), 64'd0);

        // Copy: three reads returned after 5 cycles.
        mem_lat = 5;
        base = issue_cnt;
        for (int i = 4; i < 7; i++)
            send_req(vecs[i].is_mem, vecs[i].dest, vecs[i].src, vecs[i].exp_data);
        wait_drain(100);
        chk("copy_reads", 64'(issue_cnt - base), 64'd3);

        // Order: fill must wait behind a slow read.
        mem_lat = 10;
        for (int i = 7; i < 9; i++)
            send_req(vecs[i].is_mem, vecs[i].dest, vecs[i].src, vecs[i].exp_data);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("order_withheld", 64'(writemem_valid), 64'd0);
        end
        wait_drain(100);

        // Backpressure: DEPTH accepts, then ready drops; nothing lost.
        mem_lat = 3;
        writemem_ready = 0;
        for (int i = 0; i < DEPTH; i++)
            send_req(1'b1, 26'h3000 + 26'(i), 26'h400 + 26'(i), memfn(26'h400 + 26'(i)));
        readmem_valid = 1; readmem_is_mem = 1;
        readmem_dest_addr = 26'h3000 + 26'(DEPTH); readmem_src_addr = 26'h400 + 26'(DEPTH);
        req_exp = memfn(readmem_src_addr);
        accs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) accs++;
        end
        chk("bp_extra_accepts", 64'(accs), 64'd0);
        chk("bp_ready_low", 64'(readmem_ready), 64'd0);
        chk("bp_reads_returned", 64'(rd_q.size() + ret_q.size()), 64'd0);
        writemem_ready = 1;
        if (accs == 0)
            send_req(1'b1, readmem_dest_addr, readmem_src_addr, req_exp);
        readmem_valid = 0;
        send_req(1'b1, 26'h3000 + 26'(DEPTH + 1), 26'h400 + 26'(DEPTH + 1),
                 memfn(26'h400 + 26'(DEPTH + 1)));
        wait_drain(200);

        // Arbiter stall: request held with stable address, stage blocked.
        base = issue_cnt;
        stall = 7;
        send_req(1'b1, 26'h4000, 26'h500, 8'h5C);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stall_request", 64'(mem_request), 64'd1);
            chk("stall_addr", 64'(mem_addr), 64'h500);
            chk("stall_ready_low", 64'(readmem_ready), 64'd0);
        end
        wait_drain(100);
        chk("stall_one_read", 64'(issue_cnt - base), 64'd1);

        // Reset with two reads outstanding, then stale returns.
        mem_lat = 40;
        base = issue_cnt;
        send_req(1'b1, 26'h5000, 26'h600, memfn(26'h600));
        send_req(1'b1, 26'h5001, 26'h601, memfn(26'h601));
        for (int i = 0; i < 10 && issue_cnt - base < 2; i++) tick();
        chk("pre_reset_issued", 64'(issue_cnt - base), 64'd2);
        do_reset();
        stale = 2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stale_no_valid", 64'(writemem_valid), 64'd0);
        end
        mem_lat = 3;
        send_req(1'b0, 26'h3FF, 26'h77, 8'h77);
        chk("post_reset_fill_valid", 64'(writemem_valid), 64'd1);
        chk("post_reset_fill_data", 64'(writemem_data), 64'h77);
        wait_drain(50);

        // Randomized traffic against the scoreboard.
        rand_mready = 1;
        for (int i = 0; i < 600; i++) begin
            if (!readmem_valid || last_acc) begin
                readmem_valid     = ($urandom_range(0, 9) < 7);
                readmem_is_mem    = 1'($urandom_range(0, 1));
                readmem_dest_addr = 26'($urandom);
                readmem_src_addr  = 26'($urandom);
                req_exp = readmem_is_mem ? memfn(readmem_src_addr) : readmem_src_addr[7:0];
            end
            writemem_ready = ($urandom_range(0, 3) != 0);
            mem_lat = $urandom_range(1, 6);
            tick();
        end
        readmem_valid = 0;
        writemem_ready = 1;
        rand_mready = 0;
        wait_drain(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
